// File: rtl/udp_transmit_arbiter.sv
// udp_transmit_arbiter: grants whole UDP frames from PORT_COUNT byte-stream
// requesters round-robin onto a single udp_transmit_handler byte interface.
// Optional stall watchdog with byte padding: define UDP_TRANSMIT_ARBITER_TIMEOUT_EN.
module udp_transmit_arbiter #(
    parameter int unsigned PORT_COUNT     = 4,
    parameter int unsigned INDEX_WIDTH    = $clog2(PORT_COUNT),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PORT_COUNT*9-1:0] request_data,
    input  logic [PORT_COUNT-1:0]   request_valid,
    output logic [PORT_COUNT-1:0]   request_ready,
    output logic [8:0]              data,
    output logic                    data_enable,
    input  logic                    data_ready,
    output logic                    grant_valid,
    output logic [INDEX_WIDTH-1:0]  grant_index,
    output logic                    frame_done,
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
    output logic                    timeout_error,
`endif
    output logic                    sof_error
);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] grant_q;
    logic [INDEX_WIDTH-1:0] rr_q;
    logic [3:0]             header_count_q;
    logic [7:0]             size_hi_q;
    logic [15:0]            payload_count_q;
    logic                   sof_error_q;

    logic [INDEX_WIDTH-1:0] winner;
    logic                   winner_found;
    logic                   winner_sof;
    logic [8:0]             granted_data;
    logic                   active;
    logic                   xfer;
    logic                   pad;
    logic [INDEX_WIDTH-1:0] rr_next;

    assign active       = (state_q == StHeader) || (state_q == StPayload);
    assign granted_data = request_data[32'(grant_q)*9 +: 9];
    assign winner_sof   = request_data[32'(winner)*9 + 8];
    assign rr_next      = INDEX_WIDTH'((32'(grant_q) + 32'd1) % PORT_COUNT);

    assign grant_valid = active;
    assign grant_index = grant_q;
    assign frame_done  = (state_q == StRelease);
    assign sof_error   = sof_error_q;

    // Round-robin search starting at the pointer; first valid lane wins.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        for (int unsigned k = 0; k < PORT_COUNT; k++) begin
            if (!winner_found && request_valid[(32'(rr_q) + k) % PORT_COUNT]) begin
                winner_found = 1'b1;
                winner       = INDEX_WIDTH'((32'(rr_q) + k) % PORT_COUNT);
            end
        end
    end

    // Transfer handshake, byte mux and next-state decode.
    always_comb begin
        state_d       = state_q;
        request_ready = '0;
        data          = granted_data;
        data_enable   = 1'b0;
        xfer          = 1'b0;
        if (active) begin
            if (pad) begin
                // Pad mode keeps the handler byte-aligned with zero bytes.
                data = 9'h000;
                xfer = data_ready;
            end else begin
                xfer                   = request_valid[grant_q] && data_ready;
                request_ready[grant_q] = xfer;
            end
            data_enable = xfer;
        end
        unique case (state_q)
            StIdle: begin
                if (winner_found && !reset) begin
                    if (winner_sof) state_d = StHeader;
                    else request_ready[winner] = 1'b1;  // discard stray non-SOF byte
                end
            end
            StHeader: begin
                if (xfer && header_count_q == 4'd15) begin
                    state_d = ({size_hi_q, data[7:0]} == 16'd0) ? StRelease : StPayload;
                end
            end
            StPayload: begin
                if (xfer && payload_count_q == 16'd1) state_d = StRelease;
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Frame state, grant, header/payload counters and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            grant_q         <= '0;
            rr_q            <= '0;
            header_count_q  <= '0;
            size_hi_q       <= '0;
            payload_count_q <= '0;
            sof_error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_error_q <= (state_q == StIdle) && (|request_ready);
            if (state_q == StIdle && state_d == StHeader) begin
                grant_q        <= winner;
                header_count_q <= '0;
            end
            if (state_q == StHeader && xfer) begin
                header_count_q <= header_count_q + 4'd1;
                if (header_count_q == 4'd14) size_hi_q <= data[7:0];
                if (header_count_q == 4'd15) payload_count_q <= {size_hi_q, data[7:0]};
            end
            if (state_q == StPayload && xfer) payload_count_q <= payload_count_q - 16'd1;
            if (state_q == StRelease) rr_q <= rr_next;
        end
    end

`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
    logic [15:0] stall_q;
    logic        pad_q;
    logic        timeout_q;

    // Watchdog: count cycles where the handler waits on an idle requester.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            pad_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == StRelease) begin
                stall_q <= '0;
                pad_q   <= 1'b0;
            end else if (active && !pad_q) begin
                if (xfer) begin
                    stall_q <= '0;
                end else if (data_ready && !request_valid[grant_q]) begin
                    if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        pad_q     <= 1'b1;
                        stall_q   <= '0;
                    end else begin
                        stall_q <= stall_q + 16'd1;
                    end
                end
            end
        end
    end

    assign pad           = pad_q;
    assign timeout_error = timeout_q;
`else
    assign pad = 1'b0;
`endif

endmodule

// File: tb/tb_udp_transmit_arbiter.sv
// Self-checking bench for udp_transmit_arbiter: per-lane requester queues feed
// the DUT, a scoreboard of expected handler bytes/owners is drained on data_enable.
module tb_udp_transmit_arbiter;

    localparam int P  = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [P*9-1:0] request_data = '0;
    logic [P-1:0]  request_valid = '0;
    logic [P-1:0]  request_ready;
    logic [8:0]    data;
    logic          data_enable;
    logic          data_ready = 1'b1;
    logic          grant_valid;
    logic [IW-1:0] grant_index;
    logic          frame_done;
    logic          sof_error;
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
    logic          timeout_error;
`endif

    udp_transmit_arbiter #(
        .PORT_COUNT(P),
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
        .TIMEOUT_CYCLES(8),
`endif
        .INDEX_WIDTH(IW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .request_data(request_data),
        .request_valid(request_valid),
        .request_ready(request_ready),
        .data(data),
        .data_enable(data_enable),
        .data_ready(data_ready),
        .grant_valid(grant_valid),
        .grant_index(grant_index),
        .frame_done(frame_done),
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
        .timeout_error(timeout_error),
`endif
        .sof_error(sof_error)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    logic [8:0]    lane_q [P][$];
    logic          lane_hold [P];
    logic [8:0]    exp_byte [$];
    logic [IW-1:0] exp_lane [$];
    logic          toggle_ready = 1'b0;

    int cyc = 0;
    int xfer_count, done_count, sof_err_count, discard_count, tmo_count;
    int first_xfer_cyc, last_xfer_cyc, discard_cyc, sof_err_cyc, tmo_cyc;
    int sof_cyc [$];
    int done_cyc [$];

    task automatic clear_stats();
        xfer_count = 0; done_count = 0; sof_err_count = 0; discard_count = 0; tmo_count = 0;
        first_xfer_cyc = -1; last_xfer_cyc = -1; discard_cyc = -1; sof_err_cyc = -1;
        tmo_cyc = -1;
        sof_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic flush();
        for (int i = 0; i < P; i++) begin
            lane_q[i].delete();
            lane_hold[i] = 1'b0;
        end
        exp_byte.delete();
        exp_lane.delete();
        request_valid = '0;
        request_data  = '0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        toggle_ready = 1'b0;
        data_ready   = 1'b1;
        flush();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_stats();
    endtask

    function automatic bit lanes_busy();
        for (int i = 0; i < P; i++) if (lane_q[i].size() > 0 && !lane_hold[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Queue one frame on a lane; expected bytes at index >= pad_after become zero.
    task automatic make_frame(input int lane, input int size, input int pad_after);
        logic [8:0] b;
        for (int n = 0; n < 16 + size; n++) begin
            if (n == 0) b = {1'b1, 8'($urandom)};
            else if (n == 14) b = {1'b0, 8'(size >> 8)};
            else if (n == 15) b = {1'b0, 8'(size)};
            else b = {1'b0, 8'($urandom)};
            lane_q[lane].push_back(b);
            exp_byte.push_back(n >= pad_after ? 9'h000 : b);
            exp_lane.push_back(IW'(lane));
        end
    endtask

    // One clock: drive lanes after the edge, sample outputs mid-cycle, score.
    task automatic cycle();
        logic [8:0]    eb;
        logic [IW-1:0] el;
        @(posedge clock);
        #1;
        for (int i = 0; i < P; i++) begin
            request_valid[i]       = (lane_q[i].size() > 0) && !lane_hold[i];
            request_data[i*9 +: 9] = (lane_q[i].size() > 0) ? lane_q[i][0] : 9'h000;
        end
        data_ready = toggle_ready ? ~data_ready : 1'b1;
        #1;
        cyc++;
        if (data_enable) begin
            xfer_count++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            vectors++;
            if (exp_byte.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_xfer: data=%h idx=%0d, expected no transfer",
                         data, grant_index);
            end else begin
                eb = exp_byte.pop_front();
                el = exp_lane.pop_front();
                if (eb[8]) sof_cyc.push_back(cyc);
                if (data !== eb || grant_index !== el || grant_valid !== 1'b1 ||
                    data_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL xfer: got data=%h idx=%0d gv=%b rdy=%b, expected data=%h idx=%0d gv=1 rdy=1",
                             data, grant_index, grant_valid, data_ready, eb, el);
                end
            end
        end
        if (request_ready != '0) begin
            if (!data_enable) begin
                discard_count++;
                discard_cyc = cyc;
            end
            vectors++;
            if ((request_ready & ~request_valid) != '0) begin
                miscompares++;
                $display("FAIL ready_without_valid: got ready=%b valid=%b, expected ready within valid",
                         request_ready, request_valid);
            end
        end
        for (int i = 0; i < P; i++) begin
            if (request_ready[i] && request_valid[i]) void'(lane_q[i].pop_front());
        end
        if (frame_done) begin
            done_count++;
            done_cyc.push_back(cyc);
        end
        if (sof_error) begin
            sof_err_count++;
            sof_err_cyc = cyc;
        end
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
        if (timeout_error) begin
            tmo_count++;
            tmo_cyc = cyc;
        end
`endif
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((exp_byte.size() > 0 || lanes_busy()) && n < budget) begin
            cycle();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL run_budget: got %0d bytes still pending, expected 0", exp_byte.size());
        end
        repeat (3) cycle();
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        check_int("reset_grant_valid", int'(grant_valid), 0);
        check_int("reset_grant_index", int'(grant_index), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        check_int("reset_sof_error", int'(sof_error), 0);
        check_int("reset_data_enable", int'(data_enable), 0);
        check_int("reset_request_ready", int'(request_ready), 0);
    endtask

    task automatic test_single_frame();
        do_reset();
        make_frame(0, 3, 1 << 20);
        run(200);
        check_int("single_xfers", xfer_count, 19);
        check_int("single_consecutive", last_xfer_cyc - first_xfer_cyc + 1, 19);
        check_int("single_done_count", done_count, 1);
        if (done_cyc.size() > 0) check_int("single_done_cycle", done_cyc[0], last_xfer_cyc + 1);
    endtask

    task automatic test_round_robin();
        do_reset();
        make_frame(0, 1, 1 << 20);
        make_frame(1, 1, 1 << 20);
        make_frame(3, 1, 1 << 20);
        make_frame(0, 1, 1 << 20);
        run(400);
        check_int("rr_xfers", xfer_count, 68);
        check_int("rr_done_count", done_count, 4);
        check_int("rr_frames", sof_cyc.size(), 4);
        if (sof_cyc.size() == 4 && done_cyc.size() == 4) begin
            for (int k = 0; k < 3; k++) check_int("rr_gap", sof_cyc[k+1] - done_cyc[k], 2);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        toggle_ready = 1'b1;
        make_frame(1, 4, 1 << 20);
        run(300);
        toggle_ready = 1'b0;
        check_int("bp_xfers", xfer_count, 20);
        check_int("bp_done_count", done_count, 1);
    endtask

    task automatic test_zero_and_max();
        do_reset();
        make_frame(2, 0, 1 << 20);
        run(100);
        check_int("zero_xfers", xfer_count, 16);
        check_int("zero_done_count", done_count, 1);
        if (done_cyc.size() > 0) check_int("zero_done_cycle", done_cyc[0], last_xfer_cyc + 1);
        clear_stats();
        make_frame(3, 65535, 1 << 20);
        run(70000);
        check_int("max_xfers", xfer_count, 65551);
        check_int("max_done_count", done_count, 1);
        if (done_cyc.size() > 0) check_int("max_done_cycle", done_cyc[0], last_xfer_cyc + 1);
    endtask

    task automatic test_bad_sof();
        do_reset();
        lane_q[2].push_back(9'h0AA);
        make_frame(2, 1, 1 << 20);
        run(100);
        check_int("badsof_discards", discard_count, 1);
        check_int("badsof_sof_error_count", sof_err_count, 1);
        check_int("badsof_sof_error_cycle", sof_err_cyc, discard_cyc + 1);
        check_int("badsof_xfers", xfer_count, 17);
        check_int("badsof_done_count", done_count, 1);
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        do_reset();
        make_frame(2, 2, 1 << 20);  // completes, leaving the pointer at lane 3
        run(100);
        clear_stats();
        make_frame(2, 4, 1 << 20);
        while (xfer_count < 18 && n < 100) begin
            cycle();
            n++;
        end
        check_int("mid_reached_beat", xfer_count, 18);
        reset = 1'b1;
        #1;
        check_int("mid_reset_data_enable", int'(data_enable), 0);
        check_int("mid_reset_grant_valid", int'(grant_valid), 0);
        flush();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_stats();
        make_frame(1, 1, 1 << 20);
        make_frame(3, 1, 1 << 20);
        run(200);
        check_int("mid_after_xfers", xfer_count, 34);
        check_int("mid_after_done", done_count, 2);
    endtask

`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int c;
        do_reset();
        make_frame(0, 6, 18);
        while (xfer_count < 18 && n < 100) begin
            cycle();
            n++;
        end
        check_int("tmo_reached_beat", xfer_count, 18);
        c = last_xfer_cyc;
        lane_hold[0] = 1'b1;
        run(100);
        check_int("tmo_pulses", tmo_count, 1);
        check_int("tmo_cycle", tmo_cyc, c + 9);
        check_int("tmo_xfers", xfer_count, 22);
        check_int("tmo_done_count", done_count, 1);
        flush();
    endtask
`endif

    initial begin
        for (int i = 0; i < P; i++) lane_hold[i] = 1'b0;
        clear_stats();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_bad_sof();
        test_reset_mid_frame();
`ifdef UDP_TRANSMIT_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        test_zero_and_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
